// File: rtl/boot_select.sv
// boot_select: conditions the raw user button and picks the warmboot slot.
//
// Sequence after reset: IDLE (1 cycle) -> SETTLE (SETTLE_CYCLES cycles,
// requests accepted) -> ARM (ARM_CYCLES cycles, S lines stable) -> FIRE
// (BOOT high, terminal until rst).
//
// Ports:
//   pin_clk        system clock
//   rst            synchronous reset, active-high
//   pin_button_up  raw asynchronous button, 0 = pressed
//   req_valid      software warmboot request
//   req_image      requested slot (0..3)
//   req_ready      high throughout SETTLE; handshake = req_valid & req_ready
//   btn_pressed    debounced button, active-high
//   boot_image     latched slot choice (1 = DFU, 2 = user app)
//   warmboot_s1/s0 SB_WARMBOOT slot select
//   warmboot_boot  SB_WARMBOOT BOOT strobe
module boot_select #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 255,
  parameter int ARM_CYCLES      = 4
) (
  input  logic       pin_clk,
  input  logic       rst,
  input  logic       pin_button_up,
  input  logic       req_valid,
  input  logic [1:0] req_image,
  output logic       req_ready,
  output logic       btn_pressed,
  output logic [1:0] boot_image,
  output logic       warmboot_s1,
  output logic       warmboot_s0,
  output logic       warmboot_boot
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int AW = $clog2(ARM_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [AW-1:0] ARM_LAST    = AW'(ARM_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ARM    = 2'd2,
    FIRE   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_deb;
  logic [DW-1:0]          r_deb_cnt;
  state_t                 r_state;
  logic [SW-1:0]          r_settle_cnt;
  logic [AW-1:0]          r_arm_cnt;
  logic                   r_req_ready;
  logic [1:0]             r_boot_image;
  logic                   r_s1;
  logic                   r_s0;
  logic                   r_boot;

  logic       w_sync_lvl;
  logic [1:0] w_btn_img;

  assign w_sync_lvl = r_sync[SYNC_STAGES-1];
  // Held button at decision time selects the DFU bootloader.
  assign w_btn_img  = r_deb ? 2'b10 : 2'b01;

  // Synchroniser and debouncer run regardless of FSM state. Released (1)
  // is the idle level so reset does not fake a press.
  always_ff @(posedge pin_clk) begin
    if (rst) begin
      r_sync    <= '1;
      r_deb     <= 1'b1;
      r_deb_cnt <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pin_button_up};
      if (w_sync_lvl == r_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        // Level has differed for DEBOUNCE_CYCLES cycles in a row: accept it.
        r_deb     <= w_sync_lvl;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge pin_clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
      r_arm_cnt    <= '0;
      r_req_ready  <= 1'b0;
      r_boot_image <= 2'b00;
      r_s1         <= 1'b0;
      r_s0         <= 1'b0;
      r_boot       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state      <= SETTLE;
          r_settle_cnt <= '0;
          r_req_ready  <= 1'b1;
        end
        SETTLE: begin
          // A request beats the button, even in the final settle cycle.
          if (req_valid) begin
            r_boot_image <= req_image;
            r_s1         <= req_image[1];
            r_s0         <= req_image[0];
            r_req_ready  <= 1'b0;
            r_arm_cnt    <= '0;
            r_state      <= ARM;
          end else if (r_settle_cnt == SETTLE_LAST) begin
            r_boot_image <= w_btn_img;
            r_s1         <= w_btn_img[1];
            r_s0         <= w_btn_img[0];
            r_req_ready  <= 1'b0;
            r_arm_cnt    <= '0;
            r_state      <= ARM;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        ARM: begin
          // S lines are already registered; BOOT rises only after they have
          // been stable for ARM_CYCLES cycles.
          if (r_arm_cnt == ARM_LAST) begin
            r_boot  <= 1'b1;
            r_state <= FIRE;
          end else begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
          end
        end
        FIRE: begin
          r_state <= FIRE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign btn_pressed   = ~r_deb;
  assign boot_image    = r_boot_image;
  assign warmboot_s1   = r_s1;
  assign warmboot_s0   = r_s0;
  assign warmboot_boot = r_boot;

endmodule
